dual_channel_latency_mem: RTL and testbench
===========================================

Name: dual_channel_latency_mem

Overview:
- Synthesizable two-channel byte-wide off-chip memory slave that serves the master memory bus of the HLS-generated top module (Mout_* request side, M_Rdata_ram/M_DataRdy response side).
- Sits directly downstream of the accelerator in place of a behavioural testbench memory, so the same latency model runs in RTL sims and on FPGA.
- Has programmable read/write latency, size-masked writes, and OR-merging of the slave-side responses (Sout_*).
- Provides a preload port so benches and boot logic can fill the array before start.

Parameters:
- BASE_ADDR, 0, first byte address decoded by this memory.
- MEMSIZE, 1024, number of bytes in the array (1..2048).
- ADDR_W, 11, per-channel address width.
- RD_LATENCY, 2, cycles from first oe cycle to M_DataRdy (>=1).
- WR_LATENCY, 1, cycles from first we cycle to M_DataRdy (>=1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- Mout_oe_ram  in  2  read enable, one bit per channel.
- Mout_we_ram  in  2  write enable, one bit per channel.
- Mout_addr_ram  in  2*ADDR_W  ch0 is [ADDR_W-1:0], ch1 is the upper field.
- Mout_Wdata_ram  in  16  write data, 8 bits per channel.
- Mout_data_ram_size  in  8  access size in bits, 4 bits per channel.
- Sout_Rdata_ram  in  16  slave-side read data, OR-merged into M_Rdata_ram.
- Sout_DataRdy  in  2  slave-side ready, OR-merged into M_DataRdy.
- init_we  in  1  preload write strobe.
- init_addr  in  ADDR_W  preload byte offset (relative to BASE_ADDR).
- init_data  in  8  preload byte.
- M_Rdata_ram  out  16  read data returned to the master.
- M_DataRdy  out  2  per-channel access complete.
- err_oe_we  out  2  sticky flag: oe and we both high on a channel.

Behaviour:
- Reset: the following are cleared. The array is NOT cleared.
  - both latency counters = 0
  - read delay lines = 0
  - M_Rdata_ram = Sout_Rdata_ram (delay-line contribution 0)
  - M_DataRdy = Sout_DataRdy
  - err_oe_we = 0
- in_range[c] = BASE_ADDR <= addr[c] < BASE_ADDR+MEMSIZE. Compare at ADDR_W+1 bits so the upper bound cannot wrap.
- Out-of-range access:
  - no array access, counter forced to 0, local ready 0.
  - local read data is 0; only the Sout_* contributions appear.
- Write mask per channel: mask = (1<<size)-1 truncated to 8 bits, so size>=8 gives 0xFF and size=0 gives 0x00.
  - New byte = (Wdata & mask) | (old & ~mask).
  - The array is written at every rising edge while we, in_range and not oe.
- Read: the byte at addr-BASE_ADDR is sampled every cycle into a delay line of RD_LATENCY-1 registers. M_Rdata_ram[c] = delay-line head | Sout_Rdata_ram[c].
  - RD_LATENCY=1 means no register (combinational path).
- Latency counter cnt[c], 32-bit signed, updated each rising edge:
  - if oe & in_range: cnt <= (cnt < RD_LATENCY-1) ? cnt+1 : 0.
  - elif we & in_range: cnt <= (cnt < WR_LATENCY-1) ? cnt+1 : 0.
  - else cnt <= 0.
- M_DataRdy[c] = Sout_DataRdy[c] | (in_range & ((oe & cnt==RD_LATENCY-1) | (we & cnt==WR_LATENCY-1))). This is combinational on the current request.
- Default timing: a read held from cycle k gets ready and data at cycle k+1. A write with WR_LATENCY=1 is ready in the same cycle.
- The master must hold oe/we/addr until ready. A back-to-back request restarts from cnt=0.
- Both channels write the same byte in one cycle: channel 1 wins.
- Read and write to the same byte in one cycle: the read samples the old byte.
- oe & we on a channel:
  - err_oe_we[c] sets and stays set until reset.
  - no array write occurs; the access is treated as a read.
- init_we has priority over both channels at its address. Preload is legal only while the channels are idle.
- Reset mid-access: counters and delay lines clear next edge; no ready pulse is produced for the aborted access.

Decomposition:
- Package mem_model_pkg holds:
  - constants BYTE_W=8, SIZE_W=4, N_CH=2
  - function size_to_mask
  - typedef ch_req_t {oe, we, addr, wdata, size}
- Sub-module mem_channel_ctrl, instantiated per channel, owns:
  - in_range, the latency counter, the read delay line, and M_DataRdy generation
  - the sticky error bit
- The top module owns the shared byte array and the write-priority mux.

Test Plan:
- Reset then idle:
  - Sout_Rdata_ram=0xA55A with Sout_DataRdy=2'b10 -> M_Rdata_ram=0xA55A, M_DataRdy=2'b10, err_oe_we=0.
- Preload byte 0x3C at offset 5, then ch0 oe with addr=BASE+5 held from cycle k:
  - cycle k -> ready 0.
  - cycle k+1 -> M_DataRdy[0]=1 and M_Rdata_ram[7:0]=0x3C.
  - cycle k+2, oe still held (cnt back to 0) -> ready 0.
- ch1 write 0xFF with size=4 over old byte 0x00, then read back -> 0x0F. Write 0xAB with size=8 -> readback 0xAB. Write ready appears in the same cycle as we.
- Simultaneous ch0 write 0x11 and ch1 write 0x22 to the same address -> readback 0x22. Out-of-range addr BASE+MEMSIZE -> ready 0, data 0, array unchanged.
- ch0 oe and we both high for one cycle -> err_oe_we=2'b01 and it persists. Array unchanged. Reset clears the flag.
- Assert reset at the cycle after oe is raised -> no M_DataRdy pulse. Counters read 0 after reset.

Source files
------------

// File: rtl/dual_channel_latency_mem_pkg.sv
// Shared constants, request bundle and write-mask helper for the
// two-channel latency memory.
package mem_model_pkg;

   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned SIZE_W     = 4;
   localparam int unsigned N_CH       = 2;
   localparam int unsigned MAX_ADDR_W = 16;

   typedef enum logic [1:0] {
      ACC_IDLE,
      ACC_READ,
      ACC_WRITE
   } acc_kind_e;

   typedef struct packed {
      logic                  oe;
      logic                  we;
      logic [MAX_ADDR_W-1:0] addr;
      logic [BYTE_W-1:0]     wdata;
      logic [SIZE_W-1:0]     size;
   } ch_req_t;

   // Access size in bits -> byte lane mask; sizes of a full byte or more saturate.
   function automatic logic [BYTE_W-1:0] size_to_mask(input logic [SIZE_W-1:0] size);
      logic [BYTE_W:0] full;
      full = ((BYTE_W+1)'(1) << size) - (BYTE_W+1)'(1);
      return (size >= SIZE_W'(BYTE_W)) ? '1 : full[BYTE_W-1:0];
   endfunction

endpackage

// File: rtl/dual_channel_latency_mem_if.sv
// Master memory bus between the accelerator and the latency memory,
// including the slave-side merge inputs and the preload port.
interface dual_channel_latency_mem_if #(
   parameter int unsigned ADDR_W = 11
);
   import mem_model_pkg::*;

   logic [N_CH-1:0]        Mout_oe_ram;
   logic [N_CH-1:0]        Mout_we_ram;
   logic [N_CH*ADDR_W-1:0] Mout_addr_ram;
   logic [N_CH*BYTE_W-1:0] Mout_Wdata_ram;
   logic [N_CH*SIZE_W-1:0] Mout_data_ram_size;
   logic [N_CH*BYTE_W-1:0] Sout_Rdata_ram;
   logic [N_CH-1:0]        Sout_DataRdy;
   logic                   init_we;
   logic [ADDR_W-1:0]      init_addr;
   logic [BYTE_W-1:0]      init_data;
   logic [N_CH*BYTE_W-1:0] M_Rdata_ram;
   logic [N_CH-1:0]        M_DataRdy;
   logic [N_CH-1:0]        err_oe_we;

   modport master (
      output Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram,
             Mout_data_ram_size, Sout_Rdata_ram, Sout_DataRdy,
             init_we, init_addr, init_data,
      input  M_Rdata_ram, M_DataRdy, err_oe_we
   );

   modport slave (
      input  Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram,
             Mout_data_ram_size, Sout_Rdata_ram, Sout_DataRdy,
             init_we, init_addr, init_data,
      output M_Rdata_ram, M_DataRdy, err_oe_we
   );

endinterface

// File: rtl/dual_channel_latency_mem_channel_ctrl.sv
// Per-channel control: address decode, latency counter, read delay line,
// ready generation, merged write byte and sticky oe/we conflict flag.
module mem_channel_ctrl
   import mem_model_pkg::*;
#(
   parameter int unsigned BASE_ADDR  = 0,
   parameter int unsigned MEMSIZE    = 1024,
   parameter int unsigned ADDR_W     = 11,
   parameter int unsigned RD_LATENCY = 2,
   parameter int unsigned WR_LATENCY = 1,
   parameter int unsigned IDX_W      = 10
) (
   input  logic              clock,
   input  logic              reset,
   input  ch_req_t           i_req,
   input  logic              i_sout_rdy,
   input  logic [BYTE_W-1:0] i_rd_byte,
   output logic              o_in_range,
   output logic [IDX_W-1:0]  o_index,
   output logic              o_wr_en,
   output logic [BYTE_W-1:0] o_wr_byte,
   output logic [BYTE_W-1:0] o_rdata,
   output logic              o_rdy,
   output logic              o_err
);

   localparam logic [ADDR_W:0] LO      = (ADDR_W+1)'(BASE_ADDR);
   localparam logic [ADDR_W:0] HI      = (ADDR_W+1)'(BASE_ADDR + MEMSIZE);
   localparam int              RD_LAST = int'(RD_LATENCY) - 1;
   localparam int              WR_LAST = int'(WR_LATENCY) - 1;

   logic [ADDR_W-1:0] w_addr;
   logic [ADDR_W:0]   w_addr_x;
   logic [BYTE_W-1:0] w_mask;
   logic [BYTE_W-1:0] w_head;
   acc_kind_e         w_acc;
   int                w_cnt_nxt;
   int                r_cnt;
   logic              r_err;

   assign w_addr     = i_req.addr[ADDR_W-1:0];
   assign w_addr_x   = {1'b0, w_addr};
   assign o_in_range = (w_addr_x >= LO) && (w_addr_x < HI);
   assign o_index    = IDX_W'(w_addr - LO[ADDR_W-1:0]);
   assign o_wr_en    = i_req.we & ~i_req.oe & o_in_range;

   if (ADDR_W < MAX_ADDR_W) begin : g_addr_hi
      logic [MAX_ADDR_W-ADDR_W-1:0] w_unused_addr_hi;
      assign w_unused_addr_hi = i_req.addr[MAX_ADDR_W-1:ADDR_W];
   end

   assign w_mask    = size_to_mask(i_req.size);
   assign o_wr_byte = (i_req.wdata & w_mask) | (i_rd_byte & ~w_mask);

   always_comb begin
      w_acc     = ACC_IDLE;
      w_cnt_nxt = 0;
      if (o_in_range && i_req.oe)      w_acc = ACC_READ;
      else if (o_in_range && i_req.we) w_acc = ACC_WRITE;
      case (w_acc)
         ACC_READ:  w_cnt_nxt = (r_cnt < RD_LAST) ? r_cnt + 1 : 0;
         ACC_WRITE: w_cnt_nxt = (r_cnt < WR_LAST) ? r_cnt + 1 : 0;
         default:   w_cnt_nxt = 0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt <= 0;
         r_err <= 1'b0;
      end else begin
         r_cnt <= w_cnt_nxt;
         if (i_req.oe && i_req.we) r_err <= 1'b1;
      end
   end

   if (RD_LATENCY == 1) begin : g_rd_comb
      assign w_head = i_rd_byte;
   end else begin : g_rd_dly
      localparam int unsigned DLW = (RD_LATENCY - 1) * BYTE_W;
      logic [DLW-1:0] r_dl;
      // Shift in at the LSB; the cast drops the oldest byte off the top.
      always_ff @(posedge clock) begin
         if (reset) r_dl <= '0;
         else       r_dl <= DLW'({r_dl, i_rd_byte});
      end
      assign w_head = r_dl[DLW-1 -: BYTE_W];
   end

   // Local contributions are masked during reset so an aborted access never pulses.
   assign o_rdata = reset ? '0 : w_head;
   assign o_rdy   = i_sout_rdy |
                    (~reset & o_in_range &
                     ((i_req.oe & (r_cnt == RD_LAST)) | (i_req.we & (r_cnt == WR_LAST))));
   assign o_err   = r_err;

endmodule

// File: rtl/dual_channel_latency_mem.sv
// Two-channel byte-wide latency memory slave: shared byte array, preload
// port and write-priority merge over the per-channel controllers.
module dual_channel_latency_mem
   import mem_model_pkg::*;
#(
   parameter int unsigned BASE_ADDR  = 0,
   parameter int unsigned MEMSIZE    = 1024,
   parameter int unsigned ADDR_W     = 11,
   parameter int unsigned RD_LATENCY = 2,
   parameter int unsigned WR_LATENCY = 1
) (
   input logic                        clock,
   input logic                        reset,
   dual_channel_latency_mem_if.slave  bus
);

   localparam int unsigned IDX_W = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;

   logic [BYTE_W-1:0] r_mem [MEMSIZE];

   ch_req_t           w_req     [N_CH];
   logic [IDX_W-1:0]  w_index   [N_CH];
   logic [BYTE_W-1:0] w_rd_byte [N_CH];
   logic [BYTE_W-1:0] w_wr_byte [N_CH];
   logic [BYTE_W-1:0] w_rdata   [N_CH];
   logic [N_CH-1:0]   w_in_range;
   logic [N_CH-1:0]   w_wr_en;
   logic [N_CH-1:0]   w_rdy;
   logic [N_CH-1:0]   w_err;
   logic              w_init_ok;

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      assign w_req[c] = '{
         oe:    bus.Mout_oe_ram[c],
         we:    bus.Mout_we_ram[c],
         addr:  MAX_ADDR_W'(bus.Mout_addr_ram[c*ADDR_W +: ADDR_W]),
         wdata: bus.Mout_Wdata_ram[c*BYTE_W +: BYTE_W],
         size:  bus.Mout_data_ram_size[c*SIZE_W +: SIZE_W]
      };

      assign w_rd_byte[c] = w_in_range[c] ? r_mem[w_index[c]] : '0;

      mem_channel_ctrl #(
         .BASE_ADDR  (BASE_ADDR),
         .MEMSIZE    (MEMSIZE),
         .ADDR_W     (ADDR_W),
         .RD_LATENCY (RD_LATENCY),
         .WR_LATENCY (WR_LATENCY),
         .IDX_W      (IDX_W)
      ) u_ctrl (
         .clock      (clock),
         .reset      (reset),
         .i_req      (w_req[c]),
         .i_sout_rdy (bus.Sout_DataRdy[c]),
         .i_rd_byte  (w_rd_byte[c]),
         .o_in_range (w_in_range[c]),
         .o_index    (w_index[c]),
         .o_wr_en    (w_wr_en[c]),
         .o_wr_byte  (w_wr_byte[c]),
         .o_rdata    (w_rdata[c]),
         .o_rdy      (w_rdy[c]),
         .o_err      (w_err[c])
      );

      assign bus.M_Rdata_ram[c*BYTE_W +: BYTE_W] =
         w_rdata[c] | bus.Sout_Rdata_ram[c*BYTE_W +: BYTE_W];
   end

   assign w_init_ok = bus.init_we && ({1'b0, bus.init_addr} < (ADDR_W+1)'(MEMSIZE));

   // Later assignments win: channel 1 over channel 0, preload over both.
   always_ff @(posedge clock) begin
      if (w_wr_en[0]) r_mem[w_index[0]] <= w_wr_byte[0];
      if (w_wr_en[1]) r_mem[w_index[1]] <= w_wr_byte[1];
      if (w_init_ok)  r_mem[bus.init_addr[IDX_W-1:0]] <= bus.init_data;
   end

   assign bus.M_DataRdy = w_rdy;
   assign bus.err_oe_we = w_err;

endmodule

// File: tb/tb_dual_channel_latency_mem.sv
// Directed plus randomized checks of the latency memory against a byte-array
// reference model and the read/write timing rules.
module tb_dual_channel_latency_mem;
   import mem_model_pkg::*;

   localparam int unsigned BASE = 256;
   localparam int unsigned MSZ  = 1024;
   localparam int unsigned AW   = 11;
   localparam int unsigned RDL  = 2;
   localparam int unsigned WRL  = 1;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   dual_channel_latency_mem_if #(.ADDR_W(AW)) bus ();

   dual_channel_latency_mem #(
      .BASE_ADDR  (BASE),
      .MEMSIZE    (MSZ),
      .ADDR_W     (AW),
      .RD_LATENCY (RDL),
      .WR_LATENCY (WRL)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int vectors     = 0;
   int miscompares = 0;
   logic [7:0] ref_mem [MSZ];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic sample();
      @(negedge clock);
   endtask

   task automatic idle_bus();
      bus.Mout_oe_ram        = '0;
      bus.Mout_we_ram        = '0;
      bus.Mout_addr_ram      = '0;
      bus.Mout_Wdata_ram     = '0;
      bus.Mout_data_ram_size = '0;
      bus.init_we            = 1'b0;
      bus.init_addr          = '0;
      bus.init_data          = '0;
   endtask

   task automatic set_addr(input int c, input int unsigned a);
      bus.Mout_addr_ram[c*AW +: AW] = AW'(a);
   endtask

   function automatic logic [7:0] ref_mask(input int unsigned sz);
      if (sz >= 8) return 8'hFF;
      return 8'((1 << sz) - 1);
   endfunction

   task automatic preload(input int unsigned off, input logic [7:0] d);
      bus.init_we   = 1'b1;
      bus.init_addr = AW'(off);
      bus.init_data = d;
      next_cycle();
      bus.init_we   = 1'b0;
      ref_mem[off]  = d;
   endtask

   task automatic do_read(input int c, input int unsigned off, input logic [7:0] sb, input string tag);
      logic [7:0] exp;
      exp = ref_mem[off] | sb;
      bus.Sout_Rdata_ram[c*8 +: 8] = sb;
      bus.Mout_oe_ram[c] = 1'b1;
      set_addr(c, BASE + off);
      for (int n = 0; n < int'(RDL); n++) begin
         sample();
         chk({tag, ".rdy"}, 32'(bus.M_DataRdy[c]), 32'(n == int'(RDL) - 1));
         if (n == int'(RDL) - 1) chk({tag, ".data"}, 32'(bus.M_Rdata_ram[c*8 +: 8]), 32'(exp));
         next_cycle();
      end
      bus.Mout_oe_ram[c] = 1'b0;
      bus.Sout_Rdata_ram = '0;
      set_addr(c, 0);
   endtask

   task automatic do_write(input int c, input int unsigned off, input logic [7:0] d,
                           input logic [3:0] sz, input string tag);
      logic [7:0] m;
      bus.Mout_we_ram[c] = 1'b1;
      set_addr(c, BASE + off);
      bus.Mout_Wdata_ram[c*8 +: 8]     = d;
      bus.Mout_data_ram_size[c*4 +: 4] = sz;
      sample();
      chk({tag, ".rdy"}, 32'(bus.M_DataRdy[c]), 32'(1));
      next_cycle();
      bus.Mout_we_ram[c] = 1'b0;
      set_addr(c, 0);
      m = ref_mask(int'(sz));
      ref_mem[off] = (d & m) | (ref_mem[off] & ~m);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      idle_bus();
      bus.Sout_Rdata_ram = 16'hA55A;
      bus.Sout_DataRdy   = 2'b10;
      next_cycle();
      next_cycle();
      sample();
      chk("rst.rdata", 32'(bus.M_Rdata_ram), 32'hA55A);
      chk("rst.rdy",   32'(bus.M_DataRdy),   32'h2);
      chk("rst.err",   32'(bus.err_oe_we),   32'h0);
      next_cycle();
      reset = 1'b0;
      next_cycle();
      sample();
      chk("idle.rdata", 32'(bus.M_Rdata_ram), 32'hA55A);
      chk("idle.rdy",   32'(bus.M_DataRdy),   32'h2);
      chk("idle.err",   32'(bus.err_oe_we),   32'h0);
      next_cycle();
      bus.Sout_Rdata_ram = '0;
      bus.Sout_DataRdy   = '0;

      for (int unsigned off = 0; off < MSZ; off++) preload(off, 8'($urandom));

      // Default read timing: ready one cycle after oe, then the counter wraps.
      preload(5, 8'h3C);
      bus.Mout_oe_ram[0] = 1'b1;
      set_addr(0, BASE + 5);
      sample();
      chk("rd.k.rdy", 32'(bus.M_DataRdy[0]), 32'h0);
      next_cycle();
      sample();
      chk("rd.k1.rdy",  32'(bus.M_DataRdy[0]),      32'h1);
      chk("rd.k1.data", 32'(bus.M_Rdata_ram[7:0]),  32'h3C);
      next_cycle();
      sample();
      chk("rd.k2.rdy", 32'(bus.M_DataRdy[0]), 32'h0);
      next_cycle();
      idle_bus();

      // Size-masked writes on channel 1.
      preload(40, 8'h00);
      do_write(1, 40, 8'hFF, 4'd4, "wr.sz4");
      do_read(1, 40, 8'h00, "rb.sz4");
      do_write(1, 40, 8'hAB, 4'd8, "wr.sz8");
      do_read(1, 40, 8'h00, "rb.sz8");

      // Same-byte collision: channel 1 must win.
      bus.Mout_we_ram        = 2'b11;
      set_addr(0, BASE + 60);
      set_addr(1, BASE + 60);
      bus.Mout_Wdata_ram     = 16'h2211;
      bus.Mout_data_ram_size = 8'h88;
      sample();
      chk("coll.rdy", 32'(bus.M_DataRdy), 32'h3);
      next_cycle();
      idle_bus();
      ref_mem[60] = 8'h22;
      do_read(0, 60, 8'h00, "coll.rb");

      // Out-of-range just above and just below the window.
      preload(0, 8'h5E);
      preload(MSZ - 1, 8'hC3);
      bus.Mout_oe_ram[0] = 1'b1;
      set_addr(0, BASE + MSZ);
      for (int n = 0; n < 2; n++) begin
         sample();
         chk("oor.rd.rdy",  32'(bus.M_DataRdy[0]),     32'h0);
         chk("oor.rd.data", 32'(bus.M_Rdata_ram[7:0]), 32'h0);
         next_cycle();
      end
      bus.Mout_oe_ram[0] = 1'b0;
      bus.Mout_we_ram[0] = 1'b1;
      bus.Mout_Wdata_ram[7:0] = 8'h77;
      bus.Mout_data_ram_size[3:0] = 4'd8;
      sample();
      chk("oor.wr.hi.rdy", 32'(bus.M_DataRdy[0]), 32'h0);
      next_cycle();
      set_addr(0, BASE - 1);
      sample();
      chk("oor.wr.lo.rdy", 32'(bus.M_DataRdy[0]), 32'h0);
      next_cycle();
      idle_bus();
      do_read(0, 0, 8'h00, "oor.rb0");
      do_read(0, MSZ - 1, 8'h00, "oor.rbtop");

      // oe+we conflict: sticky flag, no write.
      preload(70, 8'h99);
      bus.Mout_oe_ram[0] = 1'b1;
      bus.Mout_we_ram[0] = 1'b1;
      set_addr(0, BASE + 70);
      bus.Mout_Wdata_ram[7:0] = 8'h00;
      bus.Mout_data_ram_size[3:0] = 4'd8;
      next_cycle();
      idle_bus();
      sample();
      chk("err.set", 32'(bus.err_oe_we), 32'h1);
      next_cycle();
      sample();
      chk("err.hold", 32'(bus.err_oe_we), 32'h1);
      next_cycle();
      do_read(0, 70, 8'h00, "err.rb");
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      sample();
      chk("err.clr", 32'(bus.err_oe_we), 32'h0);
      next_cycle();

      // Reset one cycle into a read: no ready pulse, counter restarts from 0.
      bus.Mout_oe_ram[0] = 1'b1;
      set_addr(0, BASE + 5);
      sample();
      chk("rstmid.k.rdy", 32'(bus.M_DataRdy[0]), 32'h0);
      next_cycle();
      reset = 1'b1;
      sample();
      chk("rstmid.k1.rdy",  32'(bus.M_DataRdy[0]),     32'h0);
      chk("rstmid.k1.data", 32'(bus.M_Rdata_ram[7:0]), 32'h0);
      next_cycle();
      sample();
      chk("rstmid.k2.rdy", 32'(bus.M_DataRdy[0]), 32'h0);
      next_cycle();
      reset = 1'b0;
      sample();
      chk("rstmid.post0.rdy", 32'(bus.M_DataRdy[0]), 32'h0);
      next_cycle();
      sample();
      chk("rstmid.post1.rdy",  32'(bus.M_DataRdy[0]),     32'h1);
      chk("rstmid.post1.data", 32'(bus.M_Rdata_ram[7:0]), 32'(ref_mem[5]));
      next_cycle();
      idle_bus();

      // Randomized write/readback with slave-side data merged in.
      for (int i = 0; i < 40; i++) begin
         int          c;
         int unsigned off;
         c   = int'($urandom_range(0, 1));
         off = $urandom_range(0, MSZ - 1);
         if ($urandom_range(0, 1) == 1)
            do_write(c, off, 8'($urandom), 4'($urandom_range(0, 15)), "rnd.wr");
         do_read(c, off, 8'($urandom), "rnd.rd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
